// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the 5-stage pipeline hazard controller.
package pipeline_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_t;

    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_sel.sv
// EX-stage operand forwarding select for one source register; M beats W.
module fwd_sel
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rd_m,
    input  logic [REG_W-1:0] i_rd_w,
    input  logic             i_reg_write_m,
    input  logic             i_reg_write_w,
    output fwd_sel_t         o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_reg_write_m && reg_match(i_rd_m, i_rs)) begin
            o_sel = FWD_M;
        end else if (i_reg_write_w && reg_match(i_rd_w, i_rs)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, and a MEM-stage
// wait FSM with timeout for multi-cycle data memory.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 ResultSrcE0,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 MemErr,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;
    logic             w_lw_stall;
    logic             w_mem_stall;
    logic             w_err_set;
    logic             w_mem_done;
    mem_state_t       r_state;
    mem_state_t       w_state_next;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_next;
    logic             r_mem_err;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    fwd_sel u_fwd_a (
        .i_rs          (Rs1E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_sel         (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .i_rs          (Rs2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_sel         (w_fwd_b)
    );

    assign w_lw_stall = ResultSrcE0 && (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));

    // A request withdrawn mid-wait is released like a completed access.
    assign w_mem_done = MemReadyM || !MemReqM;

    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = r_tmo;
        w_mem_stall  = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    w_mem_stall  = 1'b1;
                    w_state_next = MS_WAIT;
                    w_tmo_next   = TMO_W'(1);
                end
            end
            MS_WAIT: begin
                if (w_mem_done) begin
                    w_state_next = MS_IDLE;
                    w_tmo_next   = '0;
                end else if (r_tmo == TMO_W'(MEM_TIMEOUT)) begin
                    w_err_set    = 1'b1;
                    w_state_next = MS_IDLE;
                    w_tmo_next   = '0;
                end else begin
                    w_mem_stall  = 1'b1;
                    w_tmo_next   = r_tmo + 1'b1;
                end
            end
            default: begin
                w_state_next = MS_IDLE;
                w_tmo_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MS_IDLE;
            r_tmo       <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_tmo   <= w_tmo_next;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
            if (StallF) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // A memory stall freezes E, so a taken branch there waits for the release.
    assign StallM     = w_mem_stall;
    assign StallE     = w_mem_stall;
    assign StallF     = w_mem_stall | w_lw_stall;
    assign StallD     = w_mem_stall | w_lw_stall;
    assign FlushW     = w_mem_stall;
    assign FlushE     = (w_lw_stall | PCSrcE) & ~w_mem_stall;
    assign FlushD     = PCSrcE & ~w_mem_stall;
    assign ForwardAE  = w_fwd_a;
    assign ForwardBE  = w_fwd_b;
    assign MemErr     = r_mem_err;
    assign StallCount = r_stall_cnt;

endmodule
